rf_multiport: RTL and testbench

Parametrised multi-port register file with write-to-read forwarding. It generalises the fixed 16-bit × 8, 1-write/2-read CPU register file to:
- configurable width, depth and read/write port counts;
- same-edge write forwarding;
- a coherent read stall;
- an optional hardwired zero register.

---
 rtl/rf_pkg.sv | 36 +++
 rtl/rf_multiport_if.sv | 26 ++
 rtl/rf_rd_port.sv | 44 ++++
 rtl/rf_multiport.sv | 73 +++++++
 tb/tb_rf_multiport.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared constants, write-bus payload and the forwarding function for the
// multi-port register file.
package rf_pkg;

  localparam int unsigned RF_DATA_W     = 16;
  localparam int unsigned RF_ADDR_W     = 3;

  // Ceilings for the shared write bus; narrower instances zero-extend into it.
  localparam int unsigned RF_MAX_DATA_W = 64;
  localparam int unsigned RF_MAX_ADDR_W = 8;
  localparam int unsigned RF_MAX_WR     = 2;

  typedef logic [RF_MAX_DATA_W-1:0] rf_data_t;
  typedef logic [RF_MAX_ADDR_W-1:0] rf_addr_t;

  typedef struct packed {
    logic     [RF_MAX_WR-1:0] en;
    rf_addr_t [RF_MAX_WR-1:0] sel;
    rf_data_t [RF_MAX_WR-1:0] data;
  } rf_wr_bus_t;

  // Post-write value of one entry; higher-numbered ports win a collision.
  function automatic rf_data_t next_entry(input rf_data_t   cur,
                                          input rf_addr_t   addr,
                                          input rf_wr_bus_t wr);
    rf_data_t val;
    val = cur;
    for (int unsigned k = 0; k < RF_MAX_WR; k++) begin
      if (wr.en[k] && (wr.sel[k] == addr)) begin
        val = wr.data[k];
      end
    end
    return val;
  endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// Write-back and decode-read bundle of the register file.
interface rf_multiport_if import rf_pkg::*; #(
  parameter int unsigned DATA_WIDTH = RF_DATA_W,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1
);

  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_sel;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_port;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_sel;
  logic                         rd_stall;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_port;

  modport master (
    output wr_en, wr_sel, wr_port, rd_sel, rd_stall,
    input  rd_port
  );

  modport slave (
    input  wr_en, wr_sel, wr_port, rd_sel, rd_stall,
    output rd_port
  );

endinterface

// File: rtl/rf_rd_port.sv
// One read port: held address, effective-address mux, zero mask and the
// registered read data with same-edge write forwarding.
module rf_rd_port import rf_pkg::*; #(
  parameter int unsigned DATA_WIDTH = RF_DATA_W,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] sel,
  input  logic                  stall,
  input  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH],
  input  rf_wr_bus_t            wr,
  output logic [DATA_WIDTH-1:0] data
);

  logic [ADDR_WIDTH-1:0] sel_q;
  logic [ADDR_WIDTH-1:0] a_eff;
  logic [DATA_WIDTH-1:0] data_nxt;

  assign a_eff = stall ? sel_q : sel;

  // Read the post-write value so a write on this edge is seen immediately.
  always_comb begin
    data_nxt = DATA_WIDTH'(next_entry(RF_MAX_DATA_W'(mem[a_eff]),
                                      RF_MAX_ADDR_W'(a_eff), wr));
    if ((ZERO_REG != 0) && (a_eff == '0)) begin
      data_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= '0;
      data  <= '0;
    end else begin
      if (!stall) begin
        sel_q <= sel;
      end
      data <= data_nxt;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised multi-port register file: flop storage, write decode with
// collision priority, and one forwarding read port per decode operand.
module rf_multiport import rf_pkg::*; #(
  parameter int unsigned DATA_WIDTH = RF_DATA_W,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic           clk,
  input  logic           reset,
  rf_multiport_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]            mem [DEPTH];
  logic [RF_MAX_WR-1:0]             wr_en_x;
  rf_addr_t [RF_MAX_WR-1:0]         wr_sel_x;
  rf_data_t [RF_MAX_WR-1:0]         wr_data_x;
  rf_wr_bus_t                       wr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;

  // Widen the active write ports onto the shared bus; absent ports stay idle.
  for (genvar k = 0; k < RF_MAX_WR; k++) begin : g_wr
    if (k < NUM_WR) begin : g_used
      assign wr_en_x[k]   = bus.wr_en[k];
      assign wr_sel_x[k]  = RF_MAX_ADDR_W'(bus.wr_sel[k*ADDR_WIDTH +: ADDR_WIDTH]);
      assign wr_data_x[k] = RF_MAX_DATA_W'(bus.wr_port[k*DATA_WIDTH +: DATA_WIDTH]);
    end else begin : g_idle
      assign wr_en_x[k]   = 1'b0;
      assign wr_sel_x[k]  = '0;
      assign wr_data_x[k] = '0;
    end
  end

  assign wr = '{en: wr_en_x, sel: wr_sel_x, data: wr_data_x};

  // Entry 0 is never written when it is the hardwired zero register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((ZERO_REG == 0) || (i != 0)) begin
          mem[i] <= DATA_WIDTH'(next_entry(RF_MAX_DATA_W'(mem[i]),
                                           RF_MAX_ADDR_W'(i), wr));
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    rf_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rd_port (
      .clk   (clk),
      .reset (reset),
      .sel   (bus.rd_sel[j*ADDR_WIDTH +: ADDR_WIDTH]),
      .stall (bus.rd_stall),
      .mem   (mem),
      .wr    (wr),
      .data  (rd_data[j])
    );
  end

  assign bus.rd_port = rd_data;

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: two instances (plain and zero-register) share one
// stimulus stream and are checked each cycle against an array model.
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wr_en;
  logic [5:0]  wr_sel;
  logic [31:0] wr_data;
  logic [5:0]  rd_sel;
  logic        rd_stall;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  rf_multiport_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(2), .NUM_WR(2)) bus_a ();
  rf_multiport_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(4), .NUM_WR(2)) bus_b ();

  assign bus_a.wr_en    = wr_en;
  assign bus_a.wr_sel   = wr_sel;
  assign bus_a.wr_port  = wr_data;
  assign bus_a.rd_sel   = rd_sel;
  assign bus_a.rd_stall = rd_stall;
  assign bus_b.wr_en    = wr_en;
  assign bus_b.wr_sel   = wr_sel;
  assign bus_b.wr_port  = wr_data;
  assign bus_b.rd_sel   = {rd_sel, rd_sel};
  assign bus_b.rd_stall = rd_stall;

  rf_multiport #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  rf_multiport #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(4), .NUM_WR(2), .ZERO_REG(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // Model state: instance 0 is plain, instance 1 has the zero register.
  logic [15:0] m_mem  [2][8];
  logic [2:0]  m_selq [2][4];
  logic [15:0] m_exp  [2][4];

  function automatic int nrd(input int n);
    return (n == 0) ? 2 : 4;
  endfunction

  function automatic logic [2:0] sel_of(input int j);
    logic [5:0] s;
    s = rd_sel;
    return s[(j % 2)*3 +: 3];
  endfunction

  function automatic logic [15:0] dut_rd(input int n, input int j);
    logic [31:0] a;
    logic [63:0] b;
    a = bus_a.rd_port;
    b = bus_b.rd_port;
    return (n == 0) ? a[j*16 +: 16] : b[j*16 +: 16];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Architectural behaviour: apply writes in port order, then read entries.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        for (int e = 0; e < 8; e++) m_mem[n][e] = 16'h0;
        for (int j = 0; j < 4; j++) begin
          m_selq[n][j] = 3'd0;
          m_exp[n][j]  = 16'h0;
        end
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        for (int k = 0; k < 2; k++) begin
          if (wr_en[k] && !(n == 1 && wr_sel[k*3 +: 3] == 3'd0))
            m_mem[n][wr_sel[k*3 +: 3]] = wr_data[k*16 +: 16];
        end
        for (int j = 0; j < nrd(n); j++) begin
          logic [2:0] a;
          a = rd_stall ? m_selq[n][j] : sel_of(j);
          m_exp[n][j] = (n == 1 && a == 3'd0) ? 16'h0 : m_mem[n][a];
          if (!rd_stall) m_selq[n][j] = sel_of(j);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int n = 0; n < 2; n++)
        for (int j = 0; j < nrd(n); j++)
          check($sformatf("model_t%0t_dut%0d_p%0d", $time, n, j), dut_rd(n, j), m_exp[n][j]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int k, input int a, input logic [15:0] d);
    wr_en[k]          = 1'b1;
    wr_sel[k*3 +: 3]  = 3'(a);
    wr_data[k*16 +: 16] = d;
  endtask

  task automatic rd(input int j, input int a);
    rd_sel[j*3 +: 3] = 3'(a);
  endtask

  initial begin
    reset = 1'b1; wr_en = '0; wr_sel = '0; wr_data = '0; rd_sel = '0; rd_stall = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) check($sformatf("por_a_p%0d", j), dut_rd(0, j), 16'h0);
    for (int j = 0; j < 4; j++) check($sformatf("por_b_p%0d", j), dut_rd(1, j), 16'h0);
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Write r3, read it back, then reset asynchronously mid-cycle.
    wr(0, 3, 16'h1234); tick();
    wr_en = '0; rd(0, 3); tick();
    check("r3_before_reset_a", dut_rd(0, 0), 16'h1234);
    check("r3_before_reset_b", dut_rd(1, 0), 16'h1234);
    #1 reset = 1'b1;
    wr(0, 7, 16'h7777);
    #1;
    for (int j = 0; j < 2; j++) check($sformatf("async_rst_a_p%0d", j), dut_rd(0, j), 16'h0);
    for (int j = 0; j < 4; j++) check($sformatf("async_rst_b_p%0d", j), dut_rd(1, j), 16'h0);
    tick();
    reset = 1'b0; wr_en = '0; rd(1, 7); tick();
    check("r3_after_reset", dut_rd(0, 0), 16'h0);
    check("r7_write_killed", dut_rd(0, 1), 16'h0);

    // Same-edge forwarding.
    wr(0, 5, 16'hBEEF); rd(0, 5); tick();
    check("fwd_a_p0", dut_rd(0, 0), 16'hBEEF);
    check("fwd_b_p2", dut_rd(1, 2), 16'hBEEF);
    wr_en = '0;

    // Write collision: port 1 wins, both forwarded and stored.
    wr(0, 2, 16'h1111); wr(1, 2, 16'h2222); rd(0, 2); tick();
    check("coll_fwd", dut_rd(0, 0), 16'h2222);
    wr_en = '0; tick();
    check("coll_store_a", dut_rd(0, 0), 16'h2222);
    check("coll_store_b", dut_rd(1, 0), 16'h2222);

    // Stall coherence.
    wr(0, 4, 16'h0A0A); wr(1, 6, 16'h6666); tick();
    wr_en = '0; rd(0, 4); tick();
    check("stall_pre", dut_rd(0, 0), 16'h0A0A);
    rd_stall = 1'b1; rd(0, 6); wr(0, 4, 16'h5555); tick();
    check("stall_fwd_a", dut_rd(0, 0), 16'h5555);
    check("stall_fwd_b", dut_rd(1, 0), 16'h5555);
    wr_en = '0; tick();
    check("stall_hold", dut_rd(0, 0), 16'h5555);
    rd_stall = 1'b0; tick();
    check("stall_release", dut_rd(0, 0), 16'h6666);

    // Zero register.
    wr(0, 0, 16'hFFFF); wr(1, 1, 16'h0101); rd(0, 0); rd(1, 0); tick();
    for (int j = 0; j < 4; j++) check($sformatf("zero_b_p%0d", j), dut_rd(1, j), 16'h0);
    check("zero_plain_a", dut_rd(0, 0), 16'hFFFF);
    wr_en = '0; rd(1, 1); tick();
    check("r1_b_p1", dut_rd(1, 1), 16'h0101);
    check("r1_b_p3", dut_rd(1, 3), 16'h0101);
    check("r0_b_still_zero", dut_rd(1, 0), 16'h0);

    // Mixed directed pattern; the per-cycle model check covers these.
    for (int i = 0; i < 32; i++) begin
      wr_en    = 2'(i % 4);
      wr_sel   = {3'((i * 3) % 8), 3'((i * 5 + 1) % 8)};
      wr_data  = {16'(16'h3000 + i * 16'h0111), 16'(16'hC000 + i * 16'h0203)};
      rd_sel   = {3'((i * 7 + 2) % 8), 3'((i + 4) % 8)};
      rd_stall = ((i % 5) == 2) || ((i % 5) == 3);
      tick();
    end
    wr_en = '0; rd_stall = 1'b0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
